// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request and result handshake.
//   Single-cycle opcodes (ADD, SUB, AND, OR, XOR, SHL, SHR, SRA, MOV and 10-15)
//   show their result one cycle after accept. MUL runs an iterative shift-add,
//   one multiplier bit per cycle, for WIDTH cycles. The result and flags are
//   held in DONE until the consumer takes them, and read as 0 in any other state.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     request handshake; o_ready is high only in IDLE
//   i_opcode              operation select
//   i_data1, i_data2      operands A and B (B is the shift amount for shifts)
//   o_valid / i_ready     result handshake
//   o_data, o_zero, o_neg, o_carry, o_ovf   result and flags
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_carry,
  output logic             o_ovf,
  input  logic             i_ready
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpSra = 4'd7;
  localparam logic [3:0] OpMov = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [2*WIDTH-1:0]   prod_q;   // {partial sum, remaining multiplier bits}
  logic [CntW-1:0]      cnt_q;
  logic [WIDTH-1:0]     data_q;
  logic                 zero_q, neg_q, carry_q, ovf_q;

  // Single-cycle datapath, evaluated on the live inputs at accept time.
  logic [WIDTH:0]        add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v;

  always_comb begin
    add_w = {1'b0, i_data1} + {1'b0, i_data2};
    sub_w = {1'b0, i_data1} - {1'b0, i_data2};
    // One guard bit catches the last bit shifted out; large amounts fall out naturally.
    shl_w = {1'b0, i_data1} << i_data2;
    shr_w = {i_data1, 1'b0} >> i_data2;
    sra_w = $signed({i_data1, 1'b0}) >>> i_data2;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (i_opcode)
      OpAdd: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (i_data1[WIDTH-1] == i_data2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != i_data1[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];  // borrow
        alu_v   = (i_data1[WIDTH-1] != i_data2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != i_data1[WIDTH-1]);
      end
      OpAnd: alu_res = i_data1 & i_data2;
      OpOr:  alu_res = i_data1 | i_data2;
      OpXor: alu_res = i_data1 ^ i_data2;
      OpShl: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OpShr: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OpSra: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      OpMov: alu_res = i_data2;
      default: ;
    endcase
  end

  // One shift-add step: add A to the upper half if the current multiplier bit is set.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_d;

  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
              (prod_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            if (i_opcode == OpMul) begin
              a_q     <= i_data1;
              prod_q  <= {{WIDTH{1'b0}}, i_data2};
              cnt_q   <= '0;
              state_q <= StBusy;
            end else begin
              data_q  <= alu_res;
              zero_q  <= (alu_res == '0);
              neg_q   <= alu_res[WIDTH-1];
              carry_q <= alu_c;
              ovf_q   <= alu_v;
              state_q <= StDone;
            end
          end
        end
        StBusy: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            data_q  <= prod_d[WIDTH-1:0];
            zero_q  <= (prod_d[WIDTH-1:0] == '0);
            neg_q   <= prod_d[WIDTH-1];
            carry_q <= 1'b0;
            ovf_q   <= |prod_d[2*WIDTH-1:WIDTH];
            state_q <= StDone;
          end
        end
        StDone: begin
          if (i_ready) begin
            // Clearing here keeps the outputs at 0 whenever not in DONE.
            data_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StDone);
  assign o_data  = data_q;
  assign o_zero  = zero_q;
  assign o_neg   = neg_q;
  assign o_carry = carry_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         rdy = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         o_ready, o_valid, o_zero, o_neg, o_carry, o_ovf;
  logic [W-1:0] o_data;

  alu_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .o_ready (o_ready),
    .i_opcode(op),
    .i_data1 (a),
    .i_data2 (b),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_zero  (o_zero),
    .o_neg   (o_neg),
    .o_carry (o_carry),
    .o_ovf   (o_ovf),
    .i_ready (rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } res_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         e;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic, shifts done one bit at a time.
  function automatic res_t model(input logic [3:0] mop, input logic [W-1:0] ma,
                                 input logic [W-1:0] mb);
    res_t r;
    longint ua, ub, sa, sb, t, s, smax, smin;
    int n;
    logic [W-1:0] v;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    r = '0;
    v = ma;
    n = (ub > W + 1) ? W + 1 : int'(ub);
    case (mop)
      4'd0: begin
        t = ua + ub; r.d = t[W-1:0]; r.c = (t >= (longint'(1) << W));
        s = sa + sb; r.v = (s > smax) || (s < smin);
      end
      4'd1: begin
        t = ua - ub; r.d = t[W-1:0]; r.c = (ua < ub);
        s = sa - sb; r.v = (s > smax) || (s < smin);
      end
      4'd2: r.d = ma & mb;
      4'd3: r.d = ma | mb;
      4'd4: r.d = ma ^ mb;
      4'd5: begin
        for (int i = 0; i < n; i++) begin r.c = v[W-1]; v = v << 1; end
        r.d = v;
      end
      4'd6: begin
        for (int i = 0; i < n; i++) begin r.c = v[0]; v = v >> 1; end
        r.d = v;
      end
      4'd7: begin
        for (int i = 0; i < n; i++) begin r.c = v[0]; v = {v[W-1], v[W-1:1]}; end
        r.d = v;
      end
      4'd8: r.d = mb;
      4'd9: begin
        t = ua * ub; r.d = t[W-1:0]; r.v = ((t >> W) != 0);
      end
      default: r.d = '0;
    endcase
    r.z = (r.d == '0);
    r.n = r.d[W-1];
    return r;
  endfunction

  task automatic add_vec(input logic [3:0] vop, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vd, input logic [3:0] zncv);
    vec_t x;
    x.op = vop; x.a = va; x.b = vb;
    x.e.d = vd;
    {x.e.z, x.e.n, x.e.c, x.e.v} = zncv;
    vecs.push_back(x);
  endtask

  // Compare process: every cycle out of reset, check outputs against the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(o_valid), 64'(0));
        end else begin
          check("result", 64'({o_data, o_zero, o_neg, o_carry, o_ovf}), 64'(exp_q[0]));
          if (rdy) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", 64'({o_data, o_zero, o_neg, o_carry, o_ovf}), 64'(0));
      end
    end
  end

  // Issue one operation, check latency and the literal result, optionally stall the consumer.
  task automatic run(input vec_t x, input int hold);
    int n;
    res_t got;
    @(negedge clk);
    check("ready_before_op", 64'(o_ready), 64'(1));
    rdy = (hold == 0);
    valid = 1'b1; op = x.op; a = x.a; b = x.b;
    exp_q.push_back(model(x.op, x.a, x.b));
    @(posedge clk); #1;
    valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'(x.op + 4'd3);
    n = 1;
    while (!o_valid && n < 40) begin
      check("busy_not_ready", 64'(o_ready), 64'(0));
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), (x.op == 4'd9) ? 64'(W + 1) : 64'(1));
    got = {o_data, o_zero, o_neg, o_carry, o_ovf};
    check("literal_result", 64'(got), 64'(x.e));
    for (int i = 0; i < hold; i++) begin
      valid = 1'b1; op = 4'd4; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("stall_hold", 64'({o_valid, o_ready, o_data, o_zero, o_neg, o_carry, o_ovf}),
            64'({1'b1, 1'b0, got}));
    end
    valid = 1'b0;
    rdy = 1'b1;
    if (hold > 0) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    check("back_to_idle", 64'({o_ready, o_valid}), 64'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    add_vec(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    add_vec(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    add_vec(4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    add_vec(4'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'b0110);
    add_vec(4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    add_vec(4'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
    add_vec(4'd4, 16'hFFFF, 16'h0F0F, 16'hF0F0, 4'b0100);
    add_vec(4'd8, 16'h1234, 16'h8000, 16'h8000, 4'b0100);
    add_vec(4'd7, 16'h8000, 16'd20,   16'hFFFF, 4'b0110);
    add_vec(4'd7, 16'h8004, 16'd3,    16'hF000, 4'b0110);
    add_vec(4'd7, 16'h4000, 16'd3,    16'h0800, 4'b0000);
    add_vec(4'd5, 16'h8001, 16'd1,    16'h0002, 4'b0010);
    add_vec(4'd5, 16'h8001, 16'd16,   16'h0000, 4'b1010);
    add_vec(4'd6, 16'h1234, 16'd0,    16'h1234, 4'b0000);
    add_vec(4'd6, 16'h8001, 16'd16,   16'h0000, 4'b1010);
    add_vec(4'd6, 16'h8001, 16'd17,   16'h0000, 4'b1000);
    add_vec(4'd12, 16'h0005, 16'h0005, 16'h0000, 4'b1000);
    add_vec(4'd9, 16'h0100, 16'h0100, 16'h0000, 4'b1001);
    add_vec(4'd9, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000);

    // Pin the model to the hand-computed values.
    foreach (vecs[i]) check("model_pin", 64'(model(vecs[i].op, vecs[i].a, vecs[i].b)),
                            64'(vecs[i].e));

    // Reset state.
    #2;
    check("reset_outputs", 64'({o_ready, o_valid, o_data, o_zero, o_neg, o_carry, o_ovf}),
          64'({1'b1, 1'b0, 20'h0}));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i], 0);

    // Consumer backpressure with new requests presented while the result waits.
    begin
      vec_t x;
      x.op = 4'd0; x.a = 16'h0001; x.b = 16'h0002;
      x.e.d = 16'h0003; {x.e.z, x.e.n, x.e.c, x.e.v} = 4'b0000;
      run(x, 5);
    end

    // Reset at cycle 8 of a multiply.
    @(negedge clk);
    valid = 1'b1; op = 4'd9; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mul_in_flight", 64'({o_ready, o_valid}), 64'(2'b00));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_clear",
          64'({o_ready, o_valid, o_data, o_zero, o_neg, o_carry, o_ovf}),
          64'({1'b1, 1'b0, 20'h0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      vec_t x;
      x.op = 4'd0; x.a = 16'h0002; x.b = 16'h0003;
      x.e.d = 16'h0005; {x.e.z, x.e.n, x.e.c, x.e.v} = 4'b0000;
      run(x, 0);
    end
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_mul", 64'(o_valid), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
